// File: rtl/cvp14_pkg.sv
// Shared constants and types for the CVP14 vector co-processor.
// Holds opcodes, instruction field positions, the FSM state type and the scalar write request.
package cvp14_pkg;
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 16;
  localparam int NUM_REGS  = 8;
  localparam int RIDX_W    = 3;

  localparam int OP_LSB = 12;
  localparam int D_LSB  = 9;
  localparam int S_LSB  = 6;
  localparam int T_LSB  = 3;
  localparam int IMM_W  = 8;
  localparam int OFF_W  = 9;

  localparam logic [3:0] OP_VADD  = 4'h0;
  localparam logic [3:0] OP_VSMUL = 4'h1;
  localparam logic [3:0] OP_VDOT  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SLL   = 4'h4;
  localparam logic [3:0] OP_SLH   = 4'h5;
  localparam logic [3:0] OP_VLD   = 4'h6;
  localparam logic [3:0] OP_VST   = 4'h7;
  localparam logic [3:0] OP_SLD   = 4'h8;
  localparam logic [3:0] OP_SST   = 4'h9;
  localparam logic [3:0] OP_BZ    = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  typedef logic [NUM_LANES-1:0][VEC_W-1:0] vec_t;

  // Scalar register write request; be selects the low/high byte lanes.
  typedef struct packed {
    logic              we;
    logic [1:0]        be;
    logic [RIDX_W-1:0] addr;
    logic [VEC_W-1:0]  data;
  } swr_t;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_VLD) || (op == OP_VST) || (op == OP_SLD) || (op == OP_SST);
  endfunction

  // True when a sign-extended value does not fit in signed 16 bits.
  function automatic logic out16(input logic [33:0] x);
    return !((&x[33:15]) || !(|x[33:15]));
  endfunction
endpackage

// File: rtl/cvp14_sregs.sv
// 8x16 scalar register file: two combinational read ports and one
// byte-lane-maskable write port, so SLL/SLH can update half a register.
module cvp14_sregs
  import cvp14_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RIDX_W-1:0] ra,
  input  logic [RIDX_W-1:0] rb,
  output logic [VEC_W-1:0]  da,
  output logic [VEC_W-1:0]  db,
  input  swr_t              wr
);
  logic [NUM_REGS-1:0][VEC_W-1:0] scalar;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scalar <= '0;
    end else if (wr.we) begin
      if (wr.be[0]) scalar[wr.addr][7:0]  <= wr.data[7:0];
      if (wr.be[1]) scalar[wr.addr][15:8] <= wr.data[15:8];
    end
  end

  assign da = scalar[ra];
  assign db = scalar[rb];
endmodule

// File: rtl/cvp14.sv
// CVP14 core: fetch/decode/execute FSM, 8x4x16 vector register file and
// lane datapath, sharing one address bus with a synchronous memory.
module cvp14
  import cvp14_pkg::*;
(
  input  logic        Clk1,
  input  logic        Reset,
  output logic [15:0] Addr,
  output logic        RD,
  output logic        WR,
  output logic [15:0] DataOut,
  input  logic [15:0] DataIn,
  output logic        V
);
  state_t             state;
  logic [15:0]        pc, ir;
  logic [2:0]         k;
  vec_t [NUM_REGS-1:0] vreg;

  logic [3:0]         op, nop;
  logic [RIDX_W-1:0]  fd, fs, ft, rb;
  logic [IMM_W-1:0]   imm8;
  logic [OFF_W-1:0]   off9;
  logic [VEC_W-1:0]   ss, sb, sadd;
  logic               sadd_ov;
  vec_t               vs, vt, vsum, vmul;
  logic [NUM_LANES-1:0] add_ov, mul_ov;
  logic [NUM_LANES-1:0][33:0] prod;
  logic [33:0]        dot;
  logic [1:0]         lane_m1;
  swr_t               swr;

  assign op   = ir[OP_LSB +: 4];
  assign fd   = ir[D_LSB +: RIDX_W];
  assign fs   = ir[S_LSB +: RIDX_W];
  assign ft   = ir[T_LSB +: RIDX_W];
  assign imm8 = ir[IMM_W-1:0];
  assign off9 = ir[OFF_W-1:0];
  assign nop  = DataIn[OP_LSB +: 4];

  // Port b serves St for ADD/VSMUL and Sd for BZ/SST.
  assign rb = (op == OP_ADD || op == OP_VSMUL) ? ft : fd;

  cvp14_sregs scalar (
    .clk  (Clk1),
    .rst_n(Reset),
    .ra   (fs),
    .rb   (rb),
    .da   (ss),
    .db   (sb),
    .wr   (swr)
  );

  assign vs = vreg[fs];
  assign vt = vreg[ft];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [31:0] pvv, pvs;
    assign vsum[i]   = vs[i] + vt[i];
    assign add_ov[i] = (vs[i][15] == vt[i][15]) && (vsum[i][15] != vs[i][15]);
    assign pvv       = 32'($signed(vs[i])) * 32'($signed(vt[i]));
    assign pvs       = 32'($signed(vs[i])) * 32'($signed(sb));
    assign vmul[i]   = pvs[15:0];
    assign mul_ov[i] = out16({{2{pvs[31]}}, pvs});
    assign prod[i]   = {{2{pvv[31]}}, pvv};
  end

  // 34 bits hold the exact sum of four signed 16x16 products.
  always_comb begin
    dot = '0;
    for (int i = 0; i < NUM_LANES; i++) dot = dot + prod[i];
  end

  assign sadd    = ss + sb;
  assign sadd_ov = (ss[15] == sb[15]) && (sadd[15] != ss[15]);
  assign lane_m1 = k[1:0] - 2'd1;

  always_comb begin
    swr      = '0;
    swr.addr = fd;
    swr.be   = 2'b11;
    if (state == ST_EXEC) begin
      case (op)
        OP_ADD:  begin swr.we = 1'b1; swr.data = sadd; end
        OP_VDOT: begin swr.we = 1'b1; swr.data = dot[15:0]; end
        OP_SLL:  begin swr.we = 1'b1; swr.be = 2'b01; swr.data = {8'h00, imm8}; end
        OP_SLH:  begin swr.we = 1'b1; swr.be = 2'b10; swr.data = {imm8, 8'h00}; end
        default: ;
      endcase
    end else if (state == ST_MEM && op == OP_SLD && k == 3'd1) begin
      swr.we   = 1'b1;
      swr.data = DataIn;
    end
  end

  always_ff @(posedge Clk1 or negedge Reset) begin
    if (!Reset) begin
      state <= ST_FETCH;
      pc    <= '0;
      ir    <= '0;
      k     <= '0;
      vreg  <= '0;
      V     <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
          ir <= DataIn;
          pc <= pc + 16'd1;
          k  <= '0;
          if (nop == OP_HALT)     state <= ST_HALT;
          else if (is_mem_op(nop)) state <= ST_MEM;
          else                    state <= ST_EXEC;
        end
        ST_EXEC: begin
          case (op)
            OP_VADD:  begin vreg[fd] <= vsum; V <= |add_ov; end
            OP_VSMUL: begin vreg[fd] <= vmul; V <= |mul_ov; end
            OP_VDOT:  V <= out16(dot);
            OP_ADD:   V <= sadd_ov;
            OP_BZ:    if (sb == '0) pc <= pc + {{(16-OFF_W){off9[OFF_W-1]}}, off9};
            default: ;
          endcase
          state <= ST_FETCH;
        end
        ST_MEM: begin
          k <= k + 3'd1;
          case (op)
            OP_VLD: begin
              // Read data trails the address by one cycle, so lane k-1 lands now.
              if (k != 3'd0) vreg[fd][lane_m1] <= DataIn;
              if (k == 3'd4) state <= ST_FETCH;
            end
            OP_VST:  if (k == 3'd3) state <= ST_FETCH;
            OP_SLD:  if (k == 3'd1) state <= ST_FETCH;
            default: state <= ST_FETCH;
          endcase
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH;
      endcase
    end
  end

  always_comb begin
    Addr    = pc;
    RD      = 1'b0;
    WR      = 1'b0;
    DataOut = '0;
    case (state)
      // The FSM parks in FETCH during reset; keep the strobe low until release.
      ST_FETCH: RD = Reset;
      ST_MEM: begin
        Addr = ss + {13'd0, k};
        case (op)
          OP_VLD: RD = (k < 3'd4);
          OP_VST: begin WR = 1'b1; DataOut = vreg[fd][k[1:0]]; end
          OP_SLD: RD = (k == 3'd0);
          OP_SST: begin WR = 1'b1; DataOut = sb; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_cvp14.sv
// Directed bench for cvp14: small programs run against a synchronous memory
// model, with results observed on the bus, in memory and on V.
module tb_cvp14;
  logic        Clk1 = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] Addr, DataOut, DataIn;
  logic        RD, WR, V;

  logic [15:0] mem [0:1023];
  logic        clr = 1'b0, ld_we = 1'b0;
  logic [9:0]  ld_a = '0;
  logic [15:0] ld_d = '0;
  logic [15:0] rdata = '0;

  int   checks = 0, failures = 0;
  int   first_wr;
  bit   tmo;
  logic wv [$];

  cvp14 dut (
    .Clk1(Clk1), .Reset(Reset), .Addr(Addr), .RD(RD), .WR(WR),
    .DataOut(DataOut), .DataIn(DataIn), .V(V)
  );

  always #5 Clk1 = ~Clk1;

  always @(posedge Clk1) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
    end else if (ld_we) mem[ld_a] <= ld_d;
    else if (WR) mem[Addr[9:0]] <= DataOut;
    if (RD) rdata <= mem[Addr[9:0]];
  end
  assign DataIn = rdata;

  function automatic logic [15:0] rr(input logic [3:0] op, input logic [2:0] d, s, t);
    return {op, d, s, t, 3'b000};
  endfunction
  function automatic logic [15:0] ri(input logic [3:0] op, input logic [2:0] d, input logic [7:0] imm);
    return {op, d, 1'b0, imm};
  endfunction
  function automatic logic [15:0] bz(input logic [2:0] d, input logic [8:0] off);
    return {4'hA, d, off};
  endfunction
  localparam logic [15:0] HLT = 16'hF000;

  task automatic poke(input logic [9:0] a, input logic [15:0] d);
    ld_a = a; ld_d = d; ld_we = 1'b1;
    @(negedge Clk1);
    ld_we = 1'b0;
  endtask

  task automatic load(input logic [15:0] p [$]);
    foreach (p[i]) poke(10'(i), p[i]);
  endtask

  task automatic hold_reset();
    @(negedge Clk1);
    Reset = 1'b0; clr = 1'b1;
    @(negedge Clk1);
    clr = 1'b0;
    @(negedge Clk1);
  endtask

  // Release reset and run until the bus has been idle long enough to mean HALT.
  task automatic run_prog();
    int idle;
    logic pw;
    first_wr = -1; tmo = 1'b1; idle = 0; pw = 1'b0;
    wv.delete();
    Reset = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) @(negedge Clk1);
      #1;
      if (WR && !pw) begin
        wv.push_back(V);
        if (first_wr < 0) first_wr = c;
      end
      pw = WR;
      idle = (!RD && !WR) ? idle + 1 : 0;
      if (idle >= 12) begin tmo = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    hold_reset();
    #1;
    checks++; if (Addr !== 16'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0000", Addr); end
    checks++; if (RD !== 1'b0) begin failures++; $display("FAIL rst_rd got=%b exp=0", RD); end
    checks++; if (WR !== 1'b0) begin failures++; $display("FAIL rst_wr got=%b exp=0", WR); end
    checks++; if (V !== 1'b0) begin failures++; $display("FAIL rst_v got=%b exp=0", V); end
    checks++; if (DataOut !== 16'h0) begin failures++; $display("FAIL rst_dout got=%h exp=0000", DataOut); end
    @(negedge Clk1);
    Reset = 1'b1;
    #1;
    checks++; if (RD !== 1'b1) begin failures++; $display("FAIL first_fetch_rd got=%b exp=1", RD); end
    checks++; if (Addr !== 16'h0) begin failures++; $display("FAIL first_fetch_addr got=%h exp=0000", Addr); end
  endtask

  task automatic test_scalar();
    logic [15:0] p [$];
    hold_reset();
    p = '{ri(4,0,8'h34), ri(5,0,8'h12), ri(4,1,8'hFF), rr(3,7,0,1), ri(4,6,8'h80),
          rr(9,7,6,0), ri(4,5,8'h81), rr(9,0,5,0), ri(4,4,8'h82), rr(9,1,4,0), HLT};
    load(p);
    run_prog();
    checks++; if (tmo) begin failures++; $display("FAIL scalar_timeout got=busy exp=halted"); end
    checks++; if (first_wr !== 17) begin failures++; $display("FAIL scalar_first_wr_cycle got=%0d exp=17", first_wr); end
    checks++; if (mem[10'h80] !== 16'h1333) begin failures++; $display("FAIL scalar_s7 got=%h exp=1333", mem[10'h80]); end
    checks++; if (mem[10'h81] !== 16'h1234) begin failures++; $display("FAIL scalar_s0 got=%h exp=1234", mem[10'h81]); end
    checks++; if (mem[10'h82] !== 16'h00FF) begin failures++; $display("FAIL scalar_s1 got=%h exp=00ff", mem[10'h82]); end
    checks++; if (V !== 1'b0) begin failures++; $display("FAIL scalar_v got=%b exp=0", V); end
  endtask

  task automatic test_overflow();
    logic [15:0] p [$];
    hold_reset();
    p = '{ri(4,2,8'hFF), ri(5,2,8'h7F), ri(4,3,8'h01), rr(3,4,2,3), ri(4,5,8'h90),
          rr(9,4,5,0), HLT};
    load(p);
    run_prog();
    checks++; if (tmo) begin failures++; $display("FAIL ovf_timeout got=busy exp=halted"); end
    checks++; if (mem[10'h90] !== 16'h8000) begin failures++; $display("FAIL ovf_sum got=%h exp=8000", mem[10'h90]); end
    checks++; if (V !== 1'b1) begin failures++; $display("FAIL ovf_v_held got=%b exp=1", V); end
  endtask

  task automatic test_vector();
    logic [15:0] p [$];
    hold_reset();
    p = '{ri(4,1,8'h40), rr(6,1,1,0), rr(0,2,1,1), ri(4,2,8'h50), rr(7,2,2,0),
          rr(2,5,1,1), ri(4,3,8'h60), rr(9,5,3,0), HLT};
    load(p);
    poke(10'h40, 16'd1); poke(10'h41, 16'd2); poke(10'h42, 16'd3); poke(10'h43, 16'd4);
    run_prog();
    checks++; if (tmo) begin failures++; $display("FAIL vec_timeout got=busy exp=halted"); end
    checks++; if (first_wr !== 18) begin failures++; $display("FAIL vec_first_wr_cycle got=%0d exp=18", first_wr); end
    checks++; if (mem[10'h50] !== 16'd2) begin failures++; $display("FAIL vec_lane0 got=%h exp=0002", mem[10'h50]); end
    checks++; if (mem[10'h51] !== 16'd4) begin failures++; $display("FAIL vec_lane1 got=%h exp=0004", mem[10'h51]); end
    checks++; if (mem[10'h52] !== 16'd6) begin failures++; $display("FAIL vec_lane2 got=%h exp=0006", mem[10'h52]); end
    checks++; if (mem[10'h53] !== 16'd8) begin failures++; $display("FAIL vec_lane3 got=%h exp=0008", mem[10'h53]); end
    checks++; if (mem[10'h60] !== 16'd30) begin failures++; $display("FAIL vec_dot got=%h exp=001e", mem[10'h60]); end
    checks++; if (V !== 1'b0) begin failures++; $display("FAIL vec_v got=%b exp=0", V); end
  endtask

  task automatic test_vsmul();
    logic [15:0] p [$];
    hold_reset();
    p = '{ri(4,1,8'h40), rr(6,3,1,0), ri(4,4,8'h02), rr(1,4,3,4), ri(4,2,8'h70),
          rr(7,4,2,0), ri(4,5,8'hFF), ri(5,5,8'hFF), rr(1,5,3,5), ri(4,2,8'h78),
          rr(7,5,2,0), rr(2,6,3,3), ri(4,2,8'h60), rr(9,6,2,0), HLT};
    load(p);
    poke(10'h40, 16'hFFFF); poke(10'h41, 16'h0002); poke(10'h42, 16'h0003); poke(10'h43, 16'h4000);
    run_prog();
    checks++; if (tmo) begin failures++; $display("FAIL smul_timeout got=busy exp=halted"); end
    checks++; if ({mem[10'h70], mem[10'h71], mem[10'h72], mem[10'h73]} !== 64'hFFFE_0004_0006_8000)
      begin failures++; $display("FAIL smul_pos got=%h %h %h %h exp=fffe 0004 0006 8000", mem[10'h70], mem[10'h71], mem[10'h72], mem[10'h73]); end
    checks++; if ({mem[10'h78], mem[10'h79], mem[10'h7A], mem[10'h7B]} !== 64'h0001_FFFE_FFFD_C000)
      begin failures++; $display("FAIL smul_neg got=%h %h %h %h exp=0001 fffe fffd c000", mem[10'h78], mem[10'h79], mem[10'h7A], mem[10'h7B]); end
    checks++; if (mem[10'h60] !== 16'h000E) begin failures++; $display("FAIL dot_wrap got=%h exp=000e", mem[10'h60]); end
    checks++; if (wv.size() !== 3) begin failures++; $display("FAIL smul_stores got=%0d exp=3", wv.size()); end
    else begin
      checks++; if (wv[0] !== 1'b1) begin failures++; $display("FAIL smul_ovf_v got=%b exp=1", wv[0]); end
      checks++; if (wv[1] !== 1'b0) begin failures++; $display("FAIL smul_signed_v got=%b exp=0", wv[1]); end
      checks++; if (wv[2] !== 1'b1) begin failures++; $display("FAIL dot_ovf_v got=%b exp=1", wv[2]); end
    end
  endtask

  task automatic test_branch();
    logic [15:0] p [$];
    hold_reset();
    p = '{ri(4,1,8'hA0), ri(4,2,8'h11), bz(6,9'd2), rr(9,2,1,0), rr(9,2,1,0),
          ri(4,6,8'h01), bz(6,9'd2), ri(4,3,8'hA1), rr(9,2,3,0), rr(8,4,1,0),
          ri(4,5,8'hA2), rr(9,4,5,0), HLT};
    load(p);
    poke(10'hA0, 16'hDEAD);
    run_prog();
    checks++; if (tmo) begin failures++; $display("FAIL bz_timeout got=busy exp=halted"); end
    checks++; if (first_wr !== 20) begin failures++; $display("FAIL bz_first_wr_cycle got=%0d exp=20", first_wr); end
    checks++; if (mem[10'hA0] !== 16'hDEAD) begin failures++; $display("FAIL bz_skipped got=%h exp=dead", mem[10'hA0]); end
    checks++; if (mem[10'hA1] !== 16'h0011) begin failures++; $display("FAIL bz_fallthru got=%h exp=0011", mem[10'hA1]); end
    checks++; if (mem[10'hA2] !== 16'hDEAD) begin failures++; $display("FAIL sld_copy got=%h exp=dead", mem[10'hA2]); end
  endtask

  task automatic test_halt();
    logic [15:0] p [$];
    int busy;
    hold_reset();
    p = '{HLT, ri(4,0,8'h00)};
    load(p);
    run_prog();
    checks++; if (tmo) begin failures++; $display("FAIL halt_timeout got=busy exp=halted"); end
    busy = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge Clk1); #1;
      if (RD || WR) busy++;
    end
    checks++; if (busy !== 0) begin failures++; $display("FAIL halt_bus_quiet got=%0d exp=0", busy); end
    checks++; if (mem[10'h0] !== HLT) begin failures++; $display("FAIL halt_mem0 got=%h exp=f000", mem[10'h0]); end
  endtask

  task automatic test_reset_mid_vst();
    logic [15:0] p [$];
    bit seen;
    hold_reset();
    p = '{ri(4,1,8'h40), rr(6,1,1,0), rr(0,2,1,1), ri(4,2,8'h50), rr(7,2,2,0), HLT};
    load(p);
    poke(10'h40, 16'd1); poke(10'h41, 16'd2); poke(10'h42, 16'd3); poke(10'h43, 16'd4);
    Reset = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge Clk1); #1;
      if (WR) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL midrst_store_seen got=0 exp=1"); end
    @(negedge Clk1);
    @(negedge Clk1);
    Reset = 1'b0;
    #1;
    checks++; if ({Addr, RD, WR, DataOut, V} !== 35'd0)
      begin failures++; $display("FAIL midrst_outputs got=%h %b %b %h %b exp=0000 0 0 0000 0", Addr, RD, WR, DataOut, V); end
    @(negedge Clk1);
    checks++; if ({mem[10'h50], mem[10'h51]} !== {16'd2, 16'd4})
      begin failures++; $display("FAIL midrst_partial got=%h %h exp=0002 0004", mem[10'h50], mem[10'h51]); end
    checks++; if ({mem[10'h52], mem[10'h53]} !== 32'd0)
      begin failures++; $display("FAIL midrst_cut got=%h %h exp=0000 0000", mem[10'h52], mem[10'h53]); end
  endtask

  initial begin
    test_reset();
    test_scalar();
    test_overflow();
    test_vector();
    test_vsmul();
    test_branch();
    test_halt();
    test_reset_mid_vst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
